// File: rtl/lfsr_grant_arb.sv
// ----------------------------------------------------------------------------
// lfsr_grant_arb
//
// Randomised-start round-robin arbiter. An external LFSR supplies a random
// value; its low index_width bits (mod count) pick the starting requester for
// each decision. The scan runs upward from that start with wrap-around, and
// the first active requester wins. The winner holds its grant for as long as
// its own request stays high (optionally capped by max_hold cycles). Every
// release is followed by one dead cycle before the next decision.
// lfsr_enable pulses once after each decision so the LFSR advances once per
// grant.
//
// Parameters
//   count       number of requesters (2..16)
//   index_width width of grant_index, 2**index_width >= count
//   rand_width  width of the random input, >= index_width
//   max_hold    grant cycle limit, 0 = unlimited
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous active-high reset
//   req          level-sensitive request bits, one per requester
//   random       current LFSR output
//   lfsr_enable  registered one-cycle pulse after each arbitration edge
//   grant        registered one-hot grant
//   grant_valid  high while a grant is held
//   grant_index  binary index of the granted requester
// ----------------------------------------------------------------------------
module lfsr_grant_arb #(
    parameter int count       = 4,
    parameter int index_width = 2,
    parameter int rand_width  = 8,
    parameter int max_hold    = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [count-1:0]       req,
    input  logic [rand_width-1:0]  random,
    output logic                   lfsr_enable,
    output logic [count-1:0]       grant,
    output logic                   grant_valid,
    output logic [index_width-1:0] grant_index
);

    // Enough bits to reach max_hold without wrapping; a single saturating
    // bit is all that is needed when the hold time is unlimited.
    localparam int HOLD_W = (max_hold > 0) ? $clog2(max_hold + 1) : 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]             r_state;
    logic [count-1:0]       r_grant;
    logic                   r_valid;
    logic [index_width-1:0] r_index;
    logic                   r_lfsr_en;
    logic [HOLD_W-1:0]      r_hold;

    logic [index_width-1:0] w_start;
    logic [index_width-1:0] w_winner;
    logic [count-1:0]       w_winner_oh;
    logic                   w_found;
    logic                   w_req_kept;
    logic                   w_hold_hit;
    logic                   w_release;
    logic [HOLD_W-1:0]      w_hold_nxt;
    logic                   w_unused_rand;

    // Only the low index_width bits of the LFSR take part in the decision.
    assign w_unused_rand = ^random;

    // ------------------------------------------------------------------
    // Start point and wrap-around scan.
    // Outer loop walks the scan order (start, start+1, ...); the inner
    // loop maps each scan position onto a constant requester index so
    // every req select and winner value is a constant.
    // ------------------------------------------------------------------
    always_comb begin
        w_start     = index_width'(int'(random[index_width-1:0]) % count);
        w_found     = 1'b0;
        w_winner    = '0;
        w_winner_oh = '0;
        for (int i = 0; i < count; i++) begin
            for (int j = 0; j < count; j++) begin
                if (!w_found && req[j] &&
                    (((int'(w_start) + i) % count) == j)) begin
                    w_found        = 1'b1;
                    w_winner       = index_width'(j);
                    w_winner_oh    = '0;
                    w_winner_oh[j] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Hold tracking. The counter sticks at all-ones rather than wrapping,
    // which only matters in the unlimited configuration.
    // ------------------------------------------------------------------
    assign w_hold_nxt = (&r_hold) ? r_hold : r_hold + HOLD_W'(1);

    generate
        if (max_hold > 0) begin : g_limit
            assign w_hold_hit = (w_hold_nxt == HOLD_W'(max_hold));
        end else begin : g_nolimit
            assign w_hold_hit = 1'b0;
        end
    endgenerate

    // Only the granted requester's own bit matters while holding.
    assign w_req_kept = |(req & r_grant);
    assign w_release  = !w_req_kept || w_hold_hit;

    // ------------------------------------------------------------------
    // Two-state FSM. The dead cycle after a release falls out naturally:
    // the release edge only leaves GRANT, and arbitration can only happen
    // from IDLE at the following edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_valid   <= 1'b0;
            r_index   <= '0;
            r_lfsr_en <= 1'b0;
            r_hold    <= '0;
        end else begin
            r_lfsr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state   <= S_GRANT;
                        r_grant   <= w_winner_oh;
                        r_valid   <= 1'b1;
                        r_index   <= w_winner;
                        r_hold    <= '0;
                        r_lfsr_en <= 1'b1;
                    end
                end
                S_GRANT: begin
                    r_hold <= w_hold_nxt;
                    if (w_release) begin
                        r_state <= S_IDLE;
                        r_grant <= '0;
                        r_valid <= 1'b0;
                        r_index <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign lfsr_enable = r_lfsr_en;
    assign grant       = r_grant;
    assign grant_valid = r_valid;
    assign grant_index = r_index;

endmodule

// File: tb/tb_lfsr_grant_arb.sv
// ----------------------------------------------------------------------------
// tb_lfsr_grant_arb
//
// Three arbiters share clock, reset, req and random:
//   inst 0: count=4, max_hold=0
//   inst 1: count=4, max_hold=3
//   inst 2: count=3, max_hold=0 (sees req[2:0])
// A per-instance behavioural model tracks who holds the grant, for how long,
// and whether a decision was just made; every cycle all outputs of all
// instances are compared against it. Directed sequences add explicit checks.
// ----------------------------------------------------------------------------
module tb_lfsr_grant_arb;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [7:0] rnd;

    always #5 clock = ~clock;

    logic [3:0] g0, g1;
    logic [2:0] g2;
    logic       v0, v1, v2;
    logic [1:0] i0, i1, i2;
    logic       e0, e1, e2;

    lfsr_grant_arb #(.count(4), .index_width(2), .rand_width(8), .max_hold(0)) u_a0 (
        .clock(clock), .reset(reset), .req(req), .random(rnd),
        .lfsr_enable(e0), .grant(g0), .grant_valid(v0), .grant_index(i0));

    lfsr_grant_arb #(.count(4), .index_width(2), .rand_width(8), .max_hold(3)) u_a1 (
        .clock(clock), .reset(reset), .req(req), .random(rnd),
        .lfsr_enable(e1), .grant(g1), .grant_valid(v1), .grant_index(i1));

    lfsr_grant_arb #(.count(3), .index_width(2), .rand_width(8), .max_hold(0)) u_a2 (
        .clock(clock), .reset(reset), .req(req[2:0]), .random(rnd),
        .lfsr_enable(e2), .grant(g2), .grant_valid(v2), .grant_index(i2));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int P_CNT[3] = '{4, 4, 3};
    int P_MH[3]  = '{0, 3, 0};

    bit m_gnt[3];
    int m_idx[3];
    int m_hold[3];
    bit m_en[3];

    task automatic model_reset(input int n);
        m_gnt[n]  = 1'b0;
        m_idx[n]  = 0;
        m_hold[n] = 0;
        m_en[n]   = 1'b0;
    endtask

    // One rising edge with the current req/rnd.
    task automatic model_step(input int n);
        int st;
        int k;
        m_en[n] = 1'b0;
        if (m_gnt[n]) begin
            m_hold[n]++;
            if (!req[m_idx[n]] || (P_MH[n] != 0 && m_hold[n] >= P_MH[n]))
                m_gnt[n] = 1'b0;
        end else begin
            st = (int'(rnd) % 4) % P_CNT[n];
            for (int i = 0; i < P_CNT[n]; i++) begin
                k = (st + i) % P_CNT[n];
                if (req[k]) begin
                    m_gnt[n]  = 1'b1;
                    m_idx[n]  = k;
                    m_hold[n] = 0;
                    m_en[n]   = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic cmp(input int n, input logic [3:0] g, input logic v,
                       input logic [1:0] ix, input logic e);
        logic [3:0] one;
        logic [3:0] eg;
        one = 4'b0001;
        eg  = m_gnt[n] ? (one << m_idx[n]) : 4'b0000;
        chk($sformatf("u%0d.grant", n),       32'(g),  32'(eg));
        chk($sformatf("u%0d.grant_valid", n), 32'(v),  32'(m_gnt[n]));
        chk($sformatf("u%0d.grant_index", n), 32'(ix), m_gnt[n] ? 32'(m_idx[n]) : 32'd0);
        chk($sformatf("u%0d.lfsr_enable", n), 32'(e),  32'(m_en[n]));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        for (int n = 0; n < 3; n++) begin
            if (reset) model_reset(n);
            else       model_step(n);
        end
        cmp(0, g0, v0, i0, e0);
        cmp(1, g1, v1, i1, e1);
        cmp(2, {1'b0, g2}, v2, i2, e2);
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b1111;
        rnd   = 8'h00;
        for (int n = 0; n < 3; n++) model_reset(n);

        // Reset dominates even with requests pending.
        #1;
        chk("rst.grant0", 32'(g0), 32'd0);
        chk("rst.valid0", 32'(v0), 32'd0);
        step();
        step();

        reset = 1'b0;
        req   = 4'b0000;
        rnd   = 8'hA5;
        step();
        chk("idle.valid0", 32'(v0), 32'd0);

        // start = 2 -> grant 2, enable pulses once.
        req = 4'b1111; rnd = 8'h02;
        step();
        chk("t31.grant", 32'(g0), 32'h4);
        chk("t31.index", 32'(i0), 32'd2);
        chk("t31.en",    32'(e0), 32'd1);
        step();
        chk("t31.en_off", 32'(e0), 32'd0);
        chk("t31.hold",   32'(g0), 32'h4);
        req = 4'b0000;
        step();
        step();

        // start = 3 with only req[0] -> wraps to 0.
        req = 4'b0001; rnd = 8'h03;
        step();
        chk("t32.grant", 32'(g0), 32'h1);
        chk("t32.index", 32'(i0), 32'd0);
        req = 4'b0000;
        step();
        step();

        // Hold index 1, then release and new request on the same edge.
        req = 4'b0010; rnd = 8'h00;
        step();
        chk("t33.grant", 32'(g0), 32'h2);
        step();
        step();
        chk("t33.held", 32'(g0), 32'h2);
        req = 4'b1000;
        step();
        chk("t33.release", 32'(g0), 32'h0);
        chk("t33.rel_vld", 32'(v0), 32'd0);
        step();
        chk("t33.regrant", 32'(g0), 32'h8);
        chk("t33.index",   32'(i0), 32'd3);
        req = 4'b0000;
        step();
        step();

        // max_hold = 3 forced release and re-arbitration.
        req = 4'b0100; rnd = 8'h00;
        step();
        chk("t34.v1", 32'(v1), 32'd1);
        chk("t34.e1", 32'(e1), 32'd1);
        step();
        chk("t34.v2", 32'(v1), 32'd1);
        step();
        chk("t34.v3", 32'(v1), 32'd1);
        step();
        chk("t34.dead", 32'(v1), 32'd0);
        step();
        chk("t34.regrant", 32'(v1), 32'd1);
        chk("t34.re_en",   32'(e1), 32'd1);

        // Asynchronous reset between edges, while enable is high.
        #3;
        reset = 1'b1;
        for (int n = 0; n < 3; n++) model_reset(n);
        #1;
        chk("t35.grant1", 32'(g1), 32'd0);
        chk("t35.valid1", 32'(v1), 32'd0);
        chk("t35.en1",    32'(e1), 32'd0);
        chk("t35.grant0", 32'(g0), 32'd0);
        #1;
        reset = 1'b0;
        step();
        chk("t30.first_arb", 32'(v1), 32'd1);
        chk("t30.first_en",  32'(e1), 32'd1);
        req = 4'b0000;
        step();
        step();

        // count = 3: 3 mod 3 = 0, req 3'b110 -> index 1.
        req = 4'b0110; rnd = 8'h03;
        step();
        chk("t36.grant", 32'(g2), 32'h2);
        chk("t36.index", 32'(i2), 32'd1);
        req = 4'b0000;
        step();
        step();

        // Randomised traffic, requests change only occasionally so grants
        // get held, dropped and force-released.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            rnd = 8'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_grant_arb.md
LFSR_GRANT_ARB -- requirements
Module: lfsr_grant_arb

Interface
REQ-001 The parameter count SHALL default to 4 and set the number of requesters (2..16).
REQ-002 The parameter index_width SHALL default to 2 and set the width of grant_index, with 2**index_width >= count.
REQ-003 The parameter rand_width SHALL default to 8 and set the width of the random input, with rand_width >= index_width.
REQ-004 The parameter max_hold SHALL default to 0 and set the maximum grant cycles, where 0 means unlimited.
REQ-005 Port clock  input  1 SHALL be the single rising-edge clock for all state.
REQ-006 Port reset  input  1 SHALL be an asynchronous, active-high reset.
REQ-007 Port req  input  count SHALL carry one request bit per requester, level-sensitive.
REQ-008 Port random  input  rand_width SHALL carry the pseudo-random value from the upstream LFSR (its out).
REQ-009 Port lfsr_enable  output  1 SHALL be a registered pulse that drives the upstream LFSR enable.
REQ-010 Port grant  output  count SHALL be the registered one-hot grant vector.
REQ-011 Port grant_valid  output  1 SHALL be high exactly when one grant bit is high.
REQ-012 Port grant_index  output  index_width SHALL give the binary index of the granted requester.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-014 In IDLE with req == 0, all outputs SHALL stay at reset values and random SHALL be ignored.
REQ-015 In IDLE with req != 0, start SHALL be computed as (random[index_width-1:0] mod count).
REQ-016 The winner SHALL be the first set req bit found scanning start, start+1, ... with wrap from count-1 to 0.
REQ-017 The winner SHALL be registered at that edge: grant one-hot, grant_index = winner, grant_valid = 1, state -> GRANT; latency is one edge from req sampled to grant visible.
REQ-018 lfsr_enable SHALL be 1 for exactly the one cycle following each arbitration edge and 0 otherwise, so random advances once per decision.
REQ-019 In GRANT, the grant SHALL be held unchanged while req[grant_index] is 1, and other req bits SHALL have no effect.
REQ-020 In GRANT, when req[grant_index] is sampled 0, grant, grant_valid and grant_index SHALL clear at that edge and state -> IDLE.
REQ-021 After any release there SHALL be one mandatory dead cycle, with the earliest new grant at the following edge.
REQ-022 A hold counter SHALL clear on arbitration and increment each GRANT cycle.
REQ-023 With max_hold > 0, the grant SHALL be forcibly released (as REQ-020) at the edge where the hold count reaches max_hold, even if the request is still high.
REQ-024 A requester forcibly released and still requesting SHALL re-enter arbitration normally.
REQ-025 The hold counter SHALL be wide enough for max_hold without wrap and SHALL saturate when max_hold = 0.
REQ-026 A req bit at index >= count does not exist, and random bits above index_width-1 SHALL be ignored.
REQ-027 Simultaneous release and new requests on the same edge SHALL produce release only, with the new requests served after the dead cycle.

Reset
REQ-028 While reset is high, regardless of clock, grant, grant_valid, lfsr_enable, grant_index and the hold counter SHALL be 0 and the state SHALL be IDLE.
REQ-029 Reset asserted mid-GRANT SHALL drop the grant immediately (asynchronously), with no lfsr_enable pulse.
REQ-030 After reset deasserts, the first arbitration SHALL occur at the first rising edge with req != 0.

Verification (count=4, index_width=2, max_hold=0 unless noted)
REQ-031 The bench SHALL cover: req=4'b1111, random=8'h02 -> after one edge grant=4'b0100, grant_index=2, then lfsr_enable=1 for one cycle.
REQ-032 The bench SHALL cover: req=4'b0001, random=8'h03 -> scan wraps 3->0, grant=4'b0001, grant_index=0.
REQ-033 The bench SHALL cover: granted index 1 holds while req=4'b0010, then req drops -> grant=0 at that edge, one dead cycle, and req=4'b1000 is granted at the next edge.
REQ-034 The bench SHALL cover: max_hold=3, req[2] held high -> grant_valid high exactly 3 cycles, one dead cycle, then re-granted with a new lfsr_enable pulse.
REQ-035 The bench SHALL cover: reset pulsed mid-GRANT between clock edges -> grant, grant_valid and lfsr_enable read 0 immediately and state is IDLE.
REQ-036 The bench SHALL cover: count=3, random=8'h03 -> start = 0 (3 mod 3), and req=4'b110 grants index 1.
